// File: rtl/mac_array_pkg.sv
// Shared types and constants for the MAC array sequencer.
// Holds the FSM state enum, array data widths and the pipeline latencies
// that set the drain length.
package mac_array_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        FIN    = 3'd4
    } state_e;

    // Array datapath widths.
    localparam int A_W    = 8;
    localparam int W_W    = 8;
    localparam int PSUM_W = 16;

    // Read latency of both SRAMs, in cycles.
    localparam int SRAM_LAT = 1;

    // Cycles the drain counter is loaded with after the last activation read.
    // The counter runs down to zero inclusive, so the drain lasts one cycle
    // longer than this value. That extra cycle covers the SRAM read latency.
    function automatic int drain_len(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/mac_array_ctrl_if.sv
// Job-control and array/SRAM signal bundle for the MAC array sequencer.
// The master modport is the sequencer side, and the slave modport is the
// job-control / array side.
interface mac_array_ctrl_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int NW   = 8
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic            START;
    logic [NW-1:0]   N_VEC;
    logic            W_REUSE;
    logic            BUSY;
    logic            DONE;
    logic            W_REN;
    logic [RW-1:0]   W_RADDR;
    logic [ROWS-1:0] W_LOAD;
    logic            A_REN;
    logic [NW-1:0]   A_RADDR;
    logic            ARR_EN;
    logic [COLS-1:0] COL_VALID;
    logic [ROWS-1:0] OUT_VALID;

    modport master (
        input  START, N_VEC, W_REUSE,
        output BUSY, DONE, W_REN, W_RADDR, W_LOAD, A_REN, A_RADDR,
               ARR_EN, COL_VALID, OUT_VALID
    );

    modport slave (
        output START, N_VEC, W_REUSE,
        input  BUSY, DONE, W_REN, W_RADDR, W_LOAD, A_REN, A_RADDR,
               ARR_EN, COL_VALID, OUT_VALID
    );

endinterface

// File: rtl/mac_valid_skew.sv
// Valid shift register with one output tap per stage.
// taps[i] is din delayed by i+1 cycles.
module mac_valid_skew #(
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             din,
    output logic [DEPTH-1:0] taps
);

    // Shift din in at tap 0. The oldest bit falls off the top.
    always_ff @(posedge CLK) begin
        if (RST) begin
            taps <= '0;
        end else begin
            taps <= DEPTH'({taps, din});
        end
    end

endmodule

// File: rtl/mac_array_ctrl.sv
// Sequencer for a ROWS x COLS weight-stationary MAC array.
//
// A job runs through these steps:
//   1. Optionally load the weight rows.
//   2. Stream N_VEC activation vectors.
//   3. Drain the array pipeline, then pulse DONE.
//
// state_q always holds the phase of the current cycle. Each output flop is
// loaded from a decode of the next phase, so every output is registered and
// lines up with the state it belongs to.
//
// The skewed column/row valids come from two chained shift registers that
// are fed by A_REN. Because the chain starts at A_REN, the activation SRAM
// read latency is already included in the skew.
module mac_array_ctrl
    import mac_array_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int NW   = 8
) (
    input  logic              CLK,
    input  logic              RST,
    mac_array_ctrl_if.master  bus
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DW = $clog2(drain_len(ROWS, COLS) + 1);

    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(drain_len(ROWS, COLS));

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [NW-1:0]   vec_q, vec_d;
    logic [NW-1:0]   nvec_q, nvec_d;
    logic [DW-1:0]   drain_q, drain_d;

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            w_ren_q, w_ren_d;
    logic [RW-1:0]   w_raddr_q, w_raddr_d;
    logic [ROWS-1:0] w_load_q, w_load_d;
    logic            a_ren_q, a_ren_d;
    logic [NW-1:0]   a_raddr_q, a_raddr_d;
    logic            arr_en_q, arr_en_d;

    logic [COLS-1:0] col_valid;
    logic [ROWS-1:0] out_valid;

    // Next phase, counter updates and next-cycle output decode.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        vec_d     = vec_q;
        nvec_d    = nvec_q;
        drain_d   = drain_q;

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    nvec_d  = bus.N_VEC;
                    row_d   = '0;
                    vec_d   = '0;
                    drain_d = '0;
                    if (bus.N_VEC == '0) begin
                        state_d = FIN;
                    end else if (bus.W_REUSE) begin
                        state_d = STREAM;
                    end else begin
                        state_d = LOAD_W;
                    end
                end
            end
            LOAD_W: begin
                if (row_q == ROW_LAST) begin
                    state_d = STREAM;
                    vec_d   = '0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            STREAM: begin
                if (vec_q == nvec_q - NW'(1)) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_INIT;
                end else begin
                    vec_d = vec_q + NW'(1);
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = FIN;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d    = (state_d != IDLE);
        done_d    = (state_d == FIN);
        w_ren_d   = (state_d == LOAD_W);
        w_raddr_d = w_ren_d ? row_d : '0;
        a_ren_d   = (state_d == STREAM);
        a_raddr_d = a_ren_d ? vec_d : '0;
        // The array stays enabled from the first activation arrival (one
        // cycle after the first read) until the end of the drain.
        arr_en_d  = (state_d == DRAIN) || ((state_d == STREAM) && (vec_d != '0));
        // Weight data arrives one cycle after its read. Strobe the matching row.
        w_load_d  = w_ren_q ? (ROWS'(1) << w_raddr_q) : '0;
    end

    // Phase and counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            row_q   <= '0;
            vec_q   <= '0;
            nvec_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            vec_q   <= vec_d;
            nvec_q  <= nvec_d;
            drain_q <= drain_d;
        end
    end

    // Output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            w_ren_q   <= 1'b0;
            w_raddr_q <= '0;
            w_load_q  <= '0;
            a_ren_q   <= 1'b0;
            a_raddr_q <= '0;
            arr_en_q  <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            w_ren_q   <= w_ren_d;
            w_raddr_q <= w_raddr_d;
            w_load_q  <= w_load_d;
            a_ren_q   <= a_ren_d;
            a_raddr_q <= a_raddr_d;
            arr_en_q  <= arr_en_d;
        end
    end

    // Column valid k is the activation read delayed by 1+k cycles.
    mac_valid_skew #(.DEPTH(COLS)) u_col_skew (
        .CLK  (CLK),
        .RST  (RST),
        .din  (a_ren_q),
        .taps (col_valid)
    );

    // Row results leave the right edge after the full column skew, plus r cycles.
    mac_valid_skew #(.DEPTH(ROWS)) u_row_skew (
        .CLK  (CLK),
        .RST  (RST),
        .din  (col_valid[COLS-1]),
        .taps (out_valid)
    );

    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.W_REN     = w_ren_q;
    assign bus.W_RADDR   = w_raddr_q;
    assign bus.W_LOAD    = w_load_q;
    assign bus.A_REN     = a_ren_q;
    assign bus.A_RADDR   = a_raddr_q;
    assign bus.ARR_EN    = arr_en_q;
    assign bus.COL_VALID = col_valid;
    assign bus.OUT_VALID = out_valid;

endmodule
